// File: rtl/cordic_sincos_if.sv
// -----------------------------------------------------------------------------
// cordic_sincos_if
// Handshake and result bundle for the CORDIC sine/cosine engine.
//   start   : request; a high level while the engine is idle launches a rotation
//   angle   : full-circle phase, unsigned wrap-around (2^ANGLE_W = 360 degrees)
//   busy    : high while a rotation is in progress
//   done    : one-cycle pulse, cos_out/sin_out carry a fresh result
//   cos_out : signed Q1.(DATA_W-2) cosine, held until the next done
//   sin_out : signed Q1.(DATA_W-2) sine, held until the next done
// master drives the request side, slave is the engine.
// -----------------------------------------------------------------------------
interface cordic_sincos_if #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 16
) ();
  logic                      start;
  logic [ANGLE_W-1:0]        angle;
  logic                      busy;
  logic                      done;
  logic signed [DATA_W-1:0]  cos_out;
  logic signed [DATA_W-1:0]  sin_out;

  modport master (
    output start, angle,
    input  busy, done, cos_out, sin_out
  );

  modport slave (
    input  start, angle,
    output busy, done, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_sincos_pipe.sv
// -----------------------------------------------------------------------------
// cordic_sincos_pipe
// Iterative CORDIC rotation engine producing signed sine and cosine of a
// full-circle phase. One micro-rotation per clock, ITER rotations per result,
// quadrant folding to +/-180 degrees, gain-compensated start vector and
// saturated two's-complement outputs.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : cordic_sincos_if.slave (start/angle in, busy/done/cos/sin out)
// Parameters:
//   DATA_W  : output width, Q1.(DATA_W-2), +1.0 = 2^(DATA_W-2)
//   ANGLE_W : phase width, full circle = 2^ANGLE_W
//   ITER    : number of CORDIC iterations, 4..DATA_W
// -----------------------------------------------------------------------------
module cordic_sincos_pipe #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 16,
  parameter int ITER    = 14
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cordic_sincos_if.slave   bus
);

  localparam int XW    = DATA_W + 2;   // two bits of headroom over the output
  localparam int ZW    = ANGLE_W + 1;  // signed residual angle
  localparam int CNT_W = $clog2(ITER);
  localparam real PI   = 3.14159265358979323846;

  // 2^n as a real, elaboration only
  function automatic real pow2_r(input int n);
    real r;
    r = 1.0;
    for (int k = 0; k < n; k++) begin
      r = r * 2.0;
    end
    return r;
  endfunction

  // Aggregate CORDIC gain K = prod 1/sqrt(1+2^-2i); square root by Newton steps
  function automatic real k_gain(input int n);
    real k2;
    real p;
    real r;
    k2 = 1.0;
    p  = 1.0;
    for (int i = 0; i < n; i++) begin
      k2 = k2 / (1.0 + p);
      p  = p / 4.0;
    end
    r = 1.0;
    for (int j = 0; j < 40; j++) begin
      r = 0.5 * (r + k2 / r);
    end
    return r;
  endfunction

  // atan(2^-idx) in phase units, rounded; entry 0 is exactly 45 degrees.
  // For idx >= 1 the argument is <= 0.5 so the Taylor series converges fast.
  function automatic logic signed [ZW-1:0] atan_entry(input int idx);
    real t;
    real x2;
    real sum;
    real scaled;
    logic signed [ZW-1:0] r;
    if (idx == 0) begin
      r = ZW'(64'sd1 <<< (ANGLE_W - 3));
    end else begin
      t   = 1.0 / pow2_r(idx);
      x2  = t * t;
      sum = 0.0;
      for (int k = 0; k < 40; k++) begin
        if ((k % 2) == 0) begin
          sum = sum + t / real'(2 * k + 1);
        end else begin
          sum = sum - t / real'(2 * k + 1);
        end
        t = t * x2;
      end
      scaled = sum * pow2_r(ANGLE_W) / (2.0 * PI);
      r = ZW'($rtoi(scaled + 0.5));
    end
    return r;
  endfunction

  localparam real K_GAIN = k_gain(ITER);
  localparam int  X0_INT = $rtoi(K_GAIN * pow2_r(DATA_W - 2) + 0.5);
  localparam logic signed [XW-1:0]     X0     = XW'(X0_INT);
  localparam logic signed [XW-1:0]     SAT_HI = XW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [XW-1:0]     SAT_LO = -SAT_HI;
  localparam logic signed [DATA_W-1:0] OUT_HI = DATA_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [DATA_W-1:0] OUT_LO = -OUT_HI;
  localparam logic [CNT_W-1:0]         LAST_ITER = CNT_W'(ITER - 1);

  // Clamp to the symmetric range so the most-negative code never appears
  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [XW-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_HI) begin
      r = OUT_HI;
    end else if (v < SAT_LO) begin
      r = OUT_LO;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     neg_q;
  logic [CNT_W-1:0]         iter_q;
  logic signed [XW-1:0]     x_q, y_q;
  logic signed [ZW-1:0]     z_q;
  logic signed [DATA_W-1:0] cos_q, sin_q;

  logic signed [XW-1:0]     x_d, y_d;
  logic signed [ZW-1:0]     z_d;
  logic signed [XW-1:0]     x_shift_s, y_shift_s;
  logic signed [ZW-1:0]     atan_s;
  logic signed [ZW-1:0]     atan_lut_s [ITER];
  logic                     fold_s;
  logic [ANGLE_W-1:0]       angle_fold_s;
  logic signed [ZW-1:0]     z0_s;
  logic signed [XW-1:0]     cos_full_s, sin_full_s;

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [ZW-1:0] ENTRY = atan_entry(g);
    assign atan_lut_s[g] = ENTRY;
  end

  // Quadrant fold: angles with |theta| >= 90 deg are rotated by -180 deg and
  // the result is negated at the end, keeping z inside CORDIC's convergence range.
  always_comb begin
    fold_s       = bus.angle[ANGLE_W-1] ^ bus.angle[ANGLE_W-2];
    angle_fold_s = {bus.angle[ANGLE_W-1] ^ fold_s, bus.angle[ANGLE_W-2:0]};
    z0_s         = {angle_fold_s[ANGLE_W-1], angle_fold_s};
  end

  // One CORDIC micro-rotation; direction follows the sign of the residual angle
  always_comb begin
    x_shift_s = x_q >>> iter_q;
    y_shift_s = y_q >>> iter_q;
    atan_s    = atan_lut_s[iter_q];
    if (z_q[ZW-1]) begin
      x_d = x_q + y_shift_s;
      y_d = y_q - x_shift_s;
      z_d = z_q + atan_s;
    end else begin
      x_d = x_q - y_shift_s;
      y_d = y_q + x_shift_s;
      z_d = z_q - atan_s;
    end
  end

  // Undo the quadrant fold before saturation
  always_comb begin
    if (neg_q) begin
      cos_full_s = -x_q;
      sin_full_s = -y_q;
    end else begin
      cos_full_s = x_q;
      sin_full_s = y_q;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      iter_q  <= {CNT_W{1'b0}};
      x_q     <= {XW{1'b0}};
      y_q     <= {XW{1'b0}};
      z_q     <= {ZW{1'b0}};
      cos_q   <= {DATA_W{1'b0}};
      sin_q   <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_q     <= X0;
            y_q     <= {XW{1'b0}};
            z_q     <= z0_s;
            neg_q   <= fold_s;
            iter_q  <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (iter_q == LAST_ITER) begin
            iter_q  <= {CNT_W{1'b0}};
            state_q <= ST_FINISH;
          end else begin
            iter_q <= iter_q + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          cos_q   <= sat_out(cos_full_s);
          sin_q   <= sat_out(sin_full_s);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;

endmodule
